// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared MEM/WB payload layout, skid state encoding and helpers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // MEM/WB payload: {MUX3_SELECT, REGWRITE_ENABLE, ALUOUT[32], MEM[32], RD[5]}
    localparam int unsigned RD_LSB       = 0;
    localparam int unsigned RD_W         = 5;
    localparam int unsigned MEM_LSB      = RD_LSB + RD_W;
    localparam int unsigned MEM_W        = 32;
    localparam int unsigned ALUOUT_LSB   = MEM_LSB + MEM_W;
    localparam int unsigned ALUOUT_W     = 32;
    localparam int unsigned REGWRITE_BIT = ALUOUT_LSB + ALUOUT_W;
    localparam int unsigned MUX3_BIT     = REGWRITE_BIT + 1;
    localparam int unsigned MEM_WB_WIDTH = MUX3_BIT + 1;

    function automatic logic [1:0] state_count(input skid_state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - WIDTH-wide data register with load enable and synchronous clear
module pipe_entry_reg #(
    parameter int unsigned WIDTH = 71
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q <= '0;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - two-entry MEM/WB skid buffer with stall, flush and registered outputs
module mem_wb_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH         = MEM_WB_WIDTH,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [1:0]       COUNT
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             accept;
    logic             consume;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic             data_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // Ready looks only at registered state and the stall, never at OUT_READY.
    assign IN_READY = (state_q != ST_FULL) && !BUSYWAIT;
    assign accept   = IN_VALID && IN_READY;
    assign consume  = OUT_VALID && OUT_READY && !BUSYWAIT;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !consume) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (consume && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && consume) begin
                    main_en = 1'b1;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d        = ST_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush squashes any concurrent handshake, including loads.
        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_EMPTY;
            COUNT     <= 2'd0;
            OUT_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            COUNT     <= state_count(state_d);
            OUT_VALID <= (state_d != ST_EMPTY);
        end
    end

    assign data_clr = RESET || (FLUSH && ZERO_ON_FLUSH);
    assign main_d   = main_from_skid ? skid_q : IN_DATA;

    pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
        .CLK (CLK),
        .CLR (data_clr),
        .EN  (main_en),
        .D   (main_d),
        .Q   (OUT_DATA)
    );

    pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
        .CLK (CLK),
        .CLR (data_clr),
        .EN  (skid_en),
        .D   (IN_DATA),
        .Q   (skid_q)
    );

endmodule
